mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/arb_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
// State encoding, master index type and default timeout.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef logic [0:0] mst_idx_t;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner select: a tie goes to the master not granted last.
// Driving last=0 makes master 1 win every tie (fixed priority).
module arb_pick2
  import mem_bus_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  mst_idx_t last,
  output mst_idx_t pick
);

  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter with slave-ack timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is m1 priority.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_be_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ack_i
);

  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

  arb_state_e state;
  arb_state_e state_nxt;
  mst_idx_t   gnt;
  mst_idx_t   pick;
  mst_idx_t   last;
  logic [7:0] wait_cnt;
  logic       grant;
  logic       done;
  logic       tmo;

  arb_pick2 u_pick (
    .req0 (m0_req_i),
    .req1 (m1_req_i),
    .last (last),
    .pick (pick)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last <= 1'b1;
    end else if (grant) begin
      last <= pick;
    end
  end
`else
  assign last = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack beats a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == TMO_CNT) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt       <= 1'b0;
      wait_cnt  <= '0;
      s_req_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_be_o    <= '0;
    end else if (grant) begin
      gnt       <= pick;
      wait_cnt  <= '0;
      s_req_o   <= 1'b1;
      s_we_o    <= pick[0] ? m1_we_i    : m0_we_i;
      s_addr_o  <= pick[0] ? m1_addr_i  : m0_addr_i;
      s_wdata_o <= pick[0] ? m1_wdata_i : m0_wdata_i;
      s_be_o    <= pick[0] ? m1_be_i    : m0_be_i;
    end else if (done || tmo) begin
      s_req_o <= 1'b0;
    end else if (state == BUSY) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign m0_ack_o   = done && !gnt[0];
  assign m1_ack_o   = done && gnt[0];
  assign m0_err_o   = tmo && !gnt[0];
  assign m1_err_o   = tmo && gnt[0];
  assign m0_rdata_o = m0_ack_o ? s_rdata_i : '0;
  assign m1_rdata_o = m1_ack_o ? s_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=8).
// Tie expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_req, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_be_i(m0_be), .m0_rdata_o(m0_rdata),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_be_i(m1_be), .m1_rdata_o(m1_rdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_wdata_o(s_wdata), .s_be_o(s_be), .s_rdata_i(s_rdata),
    .s_ack_i(s_ack)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    s_ack = 0; s_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    m0_req = 1;
    s_ack = 1;
    s_rdata = 32'hFFFF_FFFF;
    #3;
    tests++;
    if (s_req !== 1'b0) begin
      fails++; $display("FAIL reset_s_req got %b want 0", s_req);
    end
    tests++;
    if ({s_we, s_addr, s_wdata, s_be} !== '0) begin
      fails++; $display("FAIL reset_s_bus got %h/%h/%h/%h want 0",
                        s_we, s_addr, s_wdata, s_be);
    end
    tests++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_ack_err got %b want 0000",
                        {m0_ack, m0_err, m1_ack, m1_err});
    end
    tests++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_rdata got %h %h want 0", m0_rdata, m1_rdata);
    end
    step();
    tests++;
    if (s_req !== 1'b0) begin
      fails++; $display("FAIL reset_held_s_req got %b want 0", s_req);
    end
    idle_inputs();
    step();
    rst = 0;
    step();
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_be = 4'hF;
    #1;
    tests++;
    if (s_req !== 1'b0) begin
      fails++; $display("FAIL read_s_req_early got %b want 0", s_req);
    end
    step();
    tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0) begin
      fails++; $display("FAIL read_grant got req=%b addr=%h we=%b want 1/100/0",
                        s_req, s_addr, s_we);
    end
    step();
    step();
    tests++;
    if (m0_ack !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100) begin
      fails++; $display("FAIL read_wait got ack=%b req=%b addr=%h want 0/1/100",
                        m0_ack, s_req, s_addr);
    end
    step();
    s_ack = 1; s_rdata = 32'hCAFE_0001;
    #1;
    tests++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'hCAFE_0001) begin
      fails++; $display("FAIL read_ack got ack=%b rdata=%h want 1/cafe0001",
                        m0_ack, m0_rdata);
    end
    tests++;
    if (m1_ack !== 1'b0 || m1_err !== 1'b0 || m1_rdata !== 32'h0) begin
      fails++; $display("FAIL read_other got ack=%b err=%b rdata=%h want 0/0/0",
                        m1_ack, m1_err, m1_rdata);
    end
    step();
    s_ack = 0; m0_req = 0;
    #1;
    tests++;
    if (s_req !== 1'b0 || m0_ack !== 1'b0) begin
      fails++; $display("FAIL read_done got req=%b ack=%b want 0/0", s_req, m0_ack);
    end
    s_ack = 1;
    #1;
    tests++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000 || m0_rdata !== 32'h0) begin
      fails++; $display("FAIL idle_ack_ignored got %b rdata=%h want 0000/0",
                        {m0_ack, m1_ack, m0_err, m1_err}, m0_rdata);
    end
    step();
    s_ack = 0;
    step();
  endtask

  task automatic test_tie();
`ifdef ARB_ROUND_ROBIN_EN
    localparam int NTIE = 4;
`else
    localparam int NTIE = 2;
`endif
    int   exp_w;
    logic win_ack, lose_ack;
    do_reset();
    m0_addr = 32'h10; m1_addr = 32'h20;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < NTIE; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = k % 2;
`else
      exp_w = (k == 0) ? 1 : 0;
`endif
      step();
      tests++;
      if (s_req !== 1'b1 || s_addr !== (exp_w == 1 ? 32'h20 : 32'h10)) begin
        fails++; $display("FAIL tie_grant%0d got req=%b addr=%h want master %0d",
                          k, s_req, s_addr, exp_w);
      end
      s_ack = 1; s_rdata = 32'hA0 + k;
      #1;
      win_ack  = (exp_w == 1) ? m1_ack : m0_ack;
      lose_ack = (exp_w == 1) ? m0_ack : m1_ack;
      tests++;
      if (win_ack !== 1'b1 || lose_ack !== 1'b0) begin
        fails++; $display("FAIL tie_ack%0d got m0=%b m1=%b want master %0d",
                          k, m0_ack, m1_ack, exp_w);
      end
      step();
      s_ack = 0;
`ifndef ARB_ROUND_ROBIN_EN
      if (exp_w == 1) m1_req = 0;
`endif
      #1;
      tests++;
      if (s_req !== 1'b0) begin
        fails++; $display("FAIL tie_idle_gap%0d got req=%b want 0", k, s_req);
      end
    end
    m0_req = 0; m1_req = 0;
    step();
  endtask

  task automatic test_back_to_back();
    m1_req = 1; m1_we = 1; m1_addr = 32'h44; m1_wdata = 32'h1234_5678; m1_be = 4'h3;
    step();
    tests++;
    if (s_req !== 1'b1 || s_we !== 1'b1 || s_wdata !== 32'h1234_5678 || s_be !== 4'h3) begin
      fails++; $display("FAIL b2b_write got req=%b we=%b wdata=%h be=%h want 1/1/12345678/3",
                        s_req, s_we, s_wdata, s_be);
    end
    s_ack = 1;
    step();
    s_ack = 0;
    #1;
    tests++;
    if (s_req !== 1'b0) begin
      fails++; $display("FAIL b2b_gap got req=%b want 0", s_req);
    end
    step();
    tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h44) begin
      fails++; $display("FAIL b2b_regrant got req=%b addr=%h want 1/44", s_req, s_addr);
    end
    s_ack = 1;
    step();
    s_ack = 0; m1_req = 0;
    step();
  endtask

  task automatic test_timeout();
    m1_req = 1; m1_we = 0; m1_addr = 32'h300;
    step();
    for (int j = 1; j < 8; j++) begin
      step();
      tests++;
      if (m1_err !== 1'b0 || s_req !== 1'b1) begin
        fails++; $display("FAIL tmo_early%0d got err=%b req=%b want 0/1", j, m1_err, s_req);
      end
    end
    step();
    tests++;
    if (m1_err !== 1'b1 || m1_ack !== 1'b0 || m1_rdata !== 32'h0 || m0_err !== 1'b0) begin
      fails++; $display("FAIL tmo_err got err=%b ack=%b rdata=%h m0err=%b want 1/0/0/0",
                        m1_err, m1_ack, m1_rdata, m0_err);
    end
    step();
    m1_req = 0;
    #1;
    tests++;
    if (s_req !== 1'b0 || m1_err !== 1'b0) begin
      fails++; $display("FAIL tmo_after got req=%b err=%b want 0/0", s_req, m1_err);
    end
    step();
  endtask

  task automatic test_collision();
    m0_req = 1; m0_addr = 32'h500;
    step();
    for (int j = 1; j < 8; j++) step();
    step();
    s_ack = 1; s_rdata = 32'h0BAD_F00D;
    #1;
    tests++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL collide got ack=%b err=%b rdata=%h want 1/0/0badf00d",
                        m0_ack, m0_err, m0_rdata);
    end
    step();
    s_ack = 0; m0_req = 0;
    #1;
    tests++;
    if (s_req !== 1'b0 || m0_err !== 1'b0) begin
      fails++; $display("FAIL collide_after got req=%b err=%b want 0/0", s_req, m0_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    m0_req = 1; m0_addr = 32'h600;
    step();
    step();
    step();
    #1;
    rst = 1;
    #1;
    tests++;
    if (s_req !== 1'b0 || m0_ack !== 1'b0 || m0_err !== 1'b0) begin
      fails++; $display("FAIL rstmid got req=%b ack=%b err=%b want 0/0/0",
                        s_req, m0_ack, m0_err);
    end
    step();
    rst = 0;
    step();
    tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h600) begin
      fails++; $display("FAIL rstmid_regrant got req=%b addr=%h want 1/600", s_req, s_addr);
    end
    for (int j = 1; j < 8; j++) step();
    tests++;
    if (m0_err !== 1'b0) begin
      fails++; $display("FAIL rstmid_cnt got err=%b want 0", m0_err);
    end
    s_ack = 1;
    #1;
    tests++;
    if (m0_ack !== 1'b1) begin
      fails++; $display("FAIL rstmid_ack got ack=%b want 1", m0_ack);
    end
    step();
    s_ack = 0; m0_req = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_tie();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
